// File: rtl/axis_wdata_packer.sv
// Packs a narrow input stream into wide AXI W beats and buffers them in a small FIFO.
// Each beat carries its strobes, its wlast flag and a marker for the transfer's final beat.
//
// state  | meaning
// IDLE   | waiting for a config handshake
// ACTIVE | accepting stream words and packing beats
// DRAIN  | all words accepted, emptying the beat buffer
module axis_wdata_packer #(
    parameter int BUF_AWIDTH     = 4,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int WIDTH_RATIO    = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = DATA_WIDTH * WIDTH_RATIO,
    parameter int BURST_LEN      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic                        done,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        valid,
    output logic                        ready
);
    localparam int DEPTH = 1 << BUF_AWIDTH;
    localparam int LW    = $clog2(WIDTH_RATIO);
    localparam int BW    = $clog2(BURST_LEN + 1);
    localparam int SW    = DATA_WIDTH / 8;
    localparam int STRBW = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t                     r_state, w_state_nxt;
    logic                       r_rst_done;
    logic                       r_done;
    logic [CONFIG_DWIDTH-1:0]   r_words_rem;
    logic [LW-1:0]              r_lane;
    logic [BW-1:0]              r_burst;
    logic [AXI_DATA_WIDTH-1:0]  r_acc;
    logic [STRBW-1:0]           r_strb_acc;
    logic [BUF_AWIDTH-1:0]      r_wr_ptr, r_rd_ptr;
    logic [BUF_AWIDTH:0]        r_count;

    logic [AXI_DATA_WIDTH-1:0]  r_mem_data [DEPTH];
    logic [STRBW-1:0]           r_mem_strb [DEPTH];
    logic                       r_mem_last [DEPTH];
    logic                       r_mem_fin  [DEPTH];

    logic                       w_cfg_fire, w_in_fire, w_push, w_pop;
    logic                       w_final_word, w_last_in, w_head_fin, w_full;
    logic [AXI_DATA_WIDTH-1:0]  w_beat;
    logic [STRBW-1:0]           w_strb;

    assign w_full       = r_count[BUF_AWIDTH];
    assign axi_wvalid   = (r_count != '0);
    assign cfg_ready    = r_rst_done && (r_state == S_IDLE);
    assign ready        = (r_state == S_ACTIVE) && (r_words_rem != '0) && !w_full;
    assign done         = r_done;

    assign w_cfg_fire   = cfg_valid && cfg_ready;
    assign w_in_fire    = valid && ready;
    assign w_pop        = axi_wvalid && axi_wready;
    assign w_final_word = (r_words_rem == CONFIG_DWIDTH'(1));
    assign w_push       = w_in_fire && ((r_lane == LW'(WIDTH_RATIO - 1)) || w_final_word);
    assign w_last_in    = (r_burst == BW'(BURST_LEN - 1)) || w_final_word;
    assign w_head_fin   = r_mem_fin[r_rd_ptr];

    // Outputs are forced to zero while the buffer is empty so reset shows clean zeros.
    assign axi_wdata    = axi_wvalid ? r_mem_data[r_rd_ptr] : '0;
    assign axi_wstrb    = axi_wvalid ? r_mem_strb[r_rd_ptr] : '0;
    assign axi_wlast    = axi_wvalid ? r_mem_last[r_rd_ptr] : 1'b0;

    always_comb begin
        w_beat = r_acc;
        w_strb = r_strb_acc;
        w_beat[int'(r_lane)*DATA_WIDTH +: DATA_WIDTH] = data;
        w_strb[int'(r_lane)*SW +: SW]                 = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_cfg_fire && (cfg_length != '0)) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_in_fire && w_final_word)        w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_pop && w_head_fin)              w_state_nxt = S_IDLE;
            default:                                        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done  <= 1'b0;
            r_done      <= 1'b0;
            r_words_rem <= '0;
            r_lane      <= '0;
            r_burst     <= '0;
            r_acc       <= '0;
            r_strb_acc  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_done     <= (w_cfg_fire && (cfg_length == '0)) || (w_pop && w_head_fin);
            if (w_cfg_fire && (cfg_length != '0)) begin
                r_words_rem <= cfg_length;
                r_lane      <= '0;
                r_burst     <= '0;
                r_acc       <= '0;
                r_strb_acc  <= '0;
            end
            if (w_in_fire) begin
                r_words_rem <= r_words_rem - 1'b1;
                if (w_push) begin
                    r_acc      <= '0;
                    r_strb_acc <= '0;
                    r_lane     <= '0;
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_burst    <= w_last_in ? '0 : r_burst + 1'b1;
                end else begin
                    r_acc      <= w_beat;
                    r_strb_acc <= w_strb;
                    r_lane     <= r_lane + 1'b1;
                end
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_beat;
            r_mem_strb[r_wr_ptr] <= w_strb;
            r_mem_last[r_wr_ptr] <= w_last_in;
            r_mem_fin[r_wr_ptr]  <= w_final_word;
        end
    end
endmodule

// File: tb/tb_axis_wdata_packer.sv
// Bench for axis_wdata_packer: table-driven transfers, hand-written corner sequences and
// randomized transfers, all checked against a beat-level queue model.
module tb_axis_wdata_packer;
    localparam int R  = 8;
    localparam int BL = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  cfg_length;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         done;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wlast;
    logic         axi_wvalid;
    logic         axi_wready;
    logic [31:0]  data;
    logic         valid;
    logic         ready;

    axis_wdata_packer dut (
        .clk(clk), .rst_n(rst_n), .cfg_length(cfg_length), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .done(done), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .data(data), .valid(valid), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic         l;
        logic         f;
    } beat_t;

    typedef struct {
        int           len;
        int           vpct;
        int           wpct;
        int           beats;
        logic [31:0]  last_strb;
        bit           chk_data;
        logic [255:0] last_data;
    } vec_t;

    int           vectors = 0;
    int           miscompares = 0;
    beat_t        exp_q[$];
    logic [31:0]  words[$];
    int           w_idx, w_len;
    int           wr_pct;
    int           done_count = 0;
    int           beats_seen = 0;
    logic [31:0]  last_strb_seen;
    logic [255:0] last_data_seen;
    vec_t         tbl[8];

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        axi_wready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            axi_wready = ($urandom_range(0, 99) < wr_pct);
        end
    end

    // Monitor: beats must match the queue head whenever valid; done must follow the
    // final handshake (or a zero-length config) by exactly one cycle.
    initial begin
        bit done_due = 0;
        bit due_nxt;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due = 0;
            end else begin
                if (done || done_due) check("done_timing", done, done_due);
                if (done) done_count++;
                due_nxt = 0;
                if (cfg_valid && cfg_ready && cfg_length == 0) due_nxt = 1;
                if (axi_wvalid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_wvalid", axi_wvalid, 0);
                    end else begin
                        e = exp_q[0];
                        check("wdata", axi_wdata, e.d);
                        check("wstrb", axi_wstrb, e.s);
                        check("wlast", axi_wlast, e.l);
                        if (axi_wready) begin
                            void'(exp_q.pop_front());
                            beats_seen++;
                            if (e.f) begin
                                due_nxt = 1;
                                last_strb_seen = axi_wstrb;
                                last_data_seen = axi_wdata;
                            end
                        end
                    end
                end
                done_due = due_nxt;
            end
        end
    end

    task automatic start_cfg(int len, bit seq);
        int nb;
        bit ok;
        beat_t e;
        words.delete();
        for (int i = 0; i < len; i++) words.push_back(seq ? 32'(i + 1) : $urandom);
        w_len = len;
        w_idx = 0;
        nb = (len + R - 1) / R;
        for (int b = 0; b < nb; b++) begin
            e.d = '0;
            e.s = '0;
            for (int k = 0; k < R; k++) begin
                if (b * R + k < len) begin
                    e.d[k*32 +: 32] = words[b * R + k];
                    e.s[k*4 +: 4]   = 4'hF;
                end
            end
            e.l = ((b % BL) == BL - 1) || (b == nb - 1);
            e.f = (b == nb - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cfg_valid  = 1'b1;
        cfg_length = 32'(len);
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        check("cfg_accept", ok, 1);
    endtask

    task automatic stream(int max_cycles, int vpct);
        for (int c = 0; c < max_cycles && w_idx < w_len; c++) begin
            valid = ($urandom_range(0, 99) < vpct);
            data  = words[w_idx];
            @(negedge clk);
            if (valid && ready) w_idx++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
    endtask

    task automatic wait_done(int d0, int budget);
        for (int c = 0; c < budget && done_count == d0; c++) @(negedge clk);
        check("done_seen", done_count, d0 + 1);
        repeat (4) @(negedge clk);
        check("single_done", done_count, d0 + 1);
        check("beats_drained", exp_q.size(), 0);
    endtask

    task automatic run_vec(int len, int vpct, int wpct, bit seq, int exp_beats);
        int d0, b0;
        wr_pct = wpct;
        d0 = done_count;
        b0 = beats_seen;
        start_cfg(len, seq);
        stream(len * 10 + 200, vpct);
        check("words_accepted", w_idx, len);
        wait_done(d0, 5000);
        check("beat_count", beats_seen - b0, exp_beats);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, len;
        tbl[0] = '{8,    100, 100, 1,   32'hFFFFFFFF, 1,
                   256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001};
        tbl[1] = '{5,    100, 100, 1,   32'h000FFFFF, 1,
                   256'h00000000_00000000_00000000_00000005_00000004_00000003_00000002_00000001};
        tbl[2] = '{4092, 100, 100, 512, 32'h0000FFFF, 0, '0};
        tbl[3] = '{1,    60,  70,  1,   32'h0000000F, 1, 256'h1};
        tbl[4] = '{17,   80,  50,  3,   32'h0000000F, 0, '0};
        tbl[5] = '{128,  90,  40,  16,  32'hFFFFFFFF, 0, '0};
        tbl[6] = '{130,  70,  60,  17,  32'h000000FF, 0, '0};
        tbl[7] = '{16,   50,  30,  2,   32'hFFFFFFFF, 0, '0};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_length = '0; valid = 1'b0; data = '0; wr_pct = 100;
        #13;
        check("rst_done", done, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_wlast", axi_wlast, 0);
        check("rst_wdata", axi_wdata, 0);
        check("rst_wstrb", axi_wstrb, 0);
        check("rst_ready", ready, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("cfg_ready_after_rst", cfg_ready, 1);

        foreach (tbl[i]) begin
            run_vec(tbl[i].len, tbl[i].vpct, tbl[i].wpct, 1, tbl[i].beats);
            check("last_strb", last_strb_seen, tbl[i].last_strb);
            if (tbl[i].chk_data) check("last_data", last_data_seen, tbl[i].last_data);
        end

        // Zero-length config: done only, no beats
        wr_pct = 100;
        d0 = done_count;
        start_cfg(0, 1);
        repeat (4) @(negedge clk);
        check("zero_len_done", done_count, d0 + 1);

        // Backpressure: buffer holds 16 beats = 128 words, then input stalls
        wr_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        d0 = done_count;
        start_cfg(256, 1);
        stream(300, 100);
        check("bp_words_accepted", w_idx, 128);
        @(negedge clk);
        check("bp_ready_low", ready, 0);
        @(posedge clk);
        #1;
        wr_pct = 100;
        stream(2000, 100);
        check("bp_words_total", w_idx, 256);
        wait_done(d0, 2000);

        // Reset in the middle of a transfer
        wr_pct = 50;
        start_cfg(200, 0);
        stream(40, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wvalid", axi_wvalid, 0);
        check("mid_rst_wdata", axi_wdata, 0);
        check("mid_rst_wstrb", axi_wstrb, 0);
        check("mid_rst_wlast", axi_wlast, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_cfg_ready", cfg_ready, 0);
        check("mid_rst_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("cfg_ready_after_mid_rst", cfg_ready, 1);
        run_vec(8, 100, 100, 1, 1);
        check("post_rst_data", last_data_seen, tbl[0].last_data);
        check("post_rst_strb", last_strb_seen, 32'hFFFFFFFF);

        // Randomized transfers
        for (int t = 0; t < 12; t++) begin
            len = (t % 4 == 3) ? $urandom_range(300, 600) : $urandom_range(1, 300);
            run_vec(len, $urandom_range(30, 100), $urandom_range(20, 100), 0, (len + R - 1) / R);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axis_wdata_packer.md
AXIS_WDATA_PACKER -- requirements
Module: axis_wdata_packer

Interface
REQ-001 Parameter BUF_AWIDTH, 4, log2 of beat buffer depth (depth = 2**BUF_AWIDTH beats).
REQ-002 Parameter CONFIG_DWIDTH, 32, width of cfg_length.
REQ-003 Parameter WIDTH_RATIO, 8, stream words per AXI beat (power of two, >=2).
REQ-004 Parameter DATA_WIDTH, 32, stream word width (multiple of 8).
REQ-005 Parameter AXI_DATA_WIDTH, DATA_WIDTH*WIDTH_RATIO, AXI write data width.
REQ-006 Parameter BURST_LEN, 16, beats per AXI burst (1..256).
REQ-007 Single clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  clock, all logic on rising edge.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 cfg_length  in  CONFIG_DWIDTH  transfer length in stream words.
REQ-011 cfg_valid / cfg_ready  in / out  1  config handshake.
REQ-012 done  out  1  one-cycle pulse at transfer completion.
REQ-013 axi_wdata  out  AXI_DATA_WIDTH  packed beat.
REQ-014 axi_wstrb  out  AXI_DATA_WIDTH/8  byte strobes.
REQ-015 axi_wlast / axi_wvalid  out  1  AXI W last / valid; axi_wready  in  1.
REQ-016 data  in  DATA_WIDTH; valid  in  1; ready  out  1  input stream.

Function
REQ-017 FSM states IDLE, ACTIVE, DRAIN; transfer occurs on valid&&ready (stream), cfg_valid&&cfg_ready (config), axi_wvalid&&axi_wready (AXI).
REQ-018 IDLE: cfg_ready=1; config with cfg_length>0 latches length, clears lane/beat counters, -> ACTIVE.
REQ-019 IDLE config with cfg_length==0: done pulses next cycle, stays IDLE, no beats issued.
REQ-020 ACTIVE/DRAIN: cfg_ready=0; cfg_valid ignored.
REQ-021 ready = (state==ACTIVE) && words_remaining>0 && buffer count < depth (registered count, no same-cycle pop credit).
REQ-022 Packing: k-th accepted word of a beat goes to lanes bits [k*DATA_WIDTH +: DATA_WIDTH], k=0 first.
REQ-023 Beat pushed to buffer on the edge accepting lane WIDTH_RATIO-1 or the transfer's final word.
REQ-024 Partial final beat: unused lanes data 0, their strobes 0; used lanes strobes 1.
REQ-025 Full beats: axi_wstrb all ones.
REQ-026 Pushed beat visible on axi_wvalid the next cycle (1-cycle latency) when buffer was empty.
REQ-027 axi_wlast=1 on beat index BURST_LEN-1 of each burst and on the final beat; burst index resets after each wlast.
REQ-028 Beats total = ceil(cfg_length/WIDTH_RATIO); buffer FIFO order, no loss or duplication.
REQ-029 axi_wdata/wstrb/wlast stable while axi_wvalid && !axi_wready.
REQ-030 Final word accepted -> DRAIN; DRAIN exits to IDLE on final beat AXI handshake, done pulsing the following cycle.
REQ-031 Simultaneous push and pop: count unchanged; both occur.
REQ-032 Counters are CONFIG_DWIDTH wide; no wrap for cfg_length <= 2**CONFIG_DWIDTH-1.

Reset
REQ-033 rst_n low asynchronously: state IDLE, buffer empty, counters 0.
REQ-034 While in reset: done=0, axi_wvalid=0, axi_wlast=0, axi_wdata=0, axi_wstrb=0, ready=0, cfg_ready=0.
REQ-035 First edge after rst_n release: cfg_ready=1; reset mid-transfer discards all buffered data.

Verification
REQ-036 cfg_length=8, wready=1, words 1..8 -> one beat wdata={8,7,...,1}, wstrb=0xFFFFFFFF, wlast=1, done one cycle after handshake.
REQ-037 cfg_length=5, words 1..5 -> wdata lanes 0-4 = 1..5, lanes 5-7 = 0, wstrb=0x000FFFFF, wlast=1.
REQ-038 cfg_length=4092, continuous valid, wready=1 -> 512 beats, wlast on beats 16,32,...,512, final wstrb=0x0000FFFF, single done.
REQ-039 cfg_length=256, wready=0 -> exactly 128 words accepted then ready=0; wready=1 -> all 32 beats in order, done once.
REQ-040 cfg_length=0 -> done pulse one cycle after config, axi_wvalid never asserted.
REQ-041 rst_n low mid-burst -> outputs zero immediately; new cfg_length=8 transfer after release completes per REQ-036.
